// File: rtl/ped_pkg.sv
// Shared traffic package: pedestrian crossing state encoding, default flash
// half-period and the illegal-light helper used by the crossing controller.
package ped_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WALK  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_FAULT = 2'd3
  } ped_state_e;

  localparam int unsigned FLASH_HALF_DEF = 4;

  // More than one vehicle lamp lit at once; all-dark is tolerated.
  function automatic logic lights_illegal(input logic g, input logic y, input logic r);
    return (g & y) | (g & r) | (y & r);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input followed by a
// rising-edge detector on the synchronized level.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: latches button requests and serves them
// on the next red rise with a steady WALK phase and a flashing CLEAR phase.
module ped_crossing_ctrl
  import ped_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FLASH_HALF = FLASH_HALF_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             greenlt,
  input  logic             yellowlt,
  input  logic             redlt,
  input  logic             ped_btn,
  input  logic [CNT_W-1:0] walk_cycles,
  input  logic [CNT_W-1:0] flash_cycles,
  output logic             walk,
  output logic             dont_walk,
  output logic             ped_wait,
  output logic [CNT_W-1:0] remaining,
  output logic             abort,
  output logic             fault,
  output ped_state_e       state_dbg
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(FLASH_HALF - 1);

  ped_state_e       state, state_n;
  logic             walk_n, dont_walk_n, ped_wait_n, abort_n, fault_n;
  logic [CNT_W-1:0] remaining_n;
  logic [CNT_W-1:0] half_cnt, half_cnt_n;
  logic             btn_rise;
  logic             red_prev;
  logic             red_rise;
  logic             illegal;

  sync_edge_det u_btn_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (ped_btn),
    .rise     (btn_rise)
  );

  assign red_rise  = redlt & ~red_prev;
  assign illegal   = lights_illegal(greenlt, yellowlt, redlt);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      walk      <= 1'b0;
      dont_walk <= 1'b1;
      ped_wait  <= 1'b0;
      remaining <= '0;
      abort     <= 1'b0;
      fault     <= 1'b0;
      half_cnt  <= '0;
      red_prev  <= 1'b0;
    end else begin
      state     <= state_n;
      walk      <= walk_n;
      dont_walk <= dont_walk_n;
      ped_wait  <= ped_wait_n;
      remaining <= remaining_n;
      abort     <= abort_n;
      fault     <= fault_n;
      half_cnt  <= half_cnt_n;
      red_prev  <= redlt;
    end
  end

  // Next values are computed for the registered outputs, so every
  // branch describes what the lamps show during the following cycle.
  always_comb begin
    state_n     = state;
    walk_n      = 1'b0;
    dont_walk_n = 1'b1;
    ped_wait_n  = ped_wait | btn_rise;
    remaining_n = '0;
    abort_n     = 1'b0;
    fault_n     = fault;
    half_cnt_n  = '0;

    if (illegal || state == ST_FAULT) begin
      state_n    = ST_FAULT;
      fault_n    = 1'b1;
      ped_wait_n = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (red_rise && ped_wait) begin
            state_n     = ST_WALK;
            walk_n      = 1'b1;
            dont_walk_n = 1'b0;
            ped_wait_n  = btn_rise;
            remaining_n = (walk_cycles == '0) ? ONE : walk_cycles;
          end
        end
        ST_WALK: begin
          if (!redlt) begin
            state_n = ST_IDLE;
            abort_n = 1'b1;
          end else if (remaining <= ONE) begin
            state_n     = ST_CLEAR;
            remaining_n = (flash_cycles == '0) ? ONE : flash_cycles;
          end else begin
            walk_n      = 1'b1;
            dont_walk_n = 1'b0;
            remaining_n = remaining - ONE;
          end
        end
        ST_CLEAR: begin
          if (!redlt) begin
            state_n = ST_IDLE;
            abort_n = 1'b1;
          end else if (remaining <= ONE) begin
            state_n = ST_IDLE;
          end else begin
            remaining_n = remaining - ONE;
            // Lamp holds for FLASH_HALF cycles, then inverts.
            if (half_cnt == HALF_END) begin
              dont_walk_n = ~dont_walk;
            end else begin
              dont_walk_n = dont_walk;
              half_cnt_n  = half_cnt + ONE;
            end
          end
        end
        default: begin
          state_n = ST_FAULT;
          fault_n = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl: normal crossing, late request,
// abort, fault, zero-length walk and reset during clearance.
module tb_ped_crossing_ctrl;
  import ped_pkg::*;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             greenlt, yellowlt, redlt;
  logic             ped_btn;
  logic [CNT_W-1:0] walk_cycles, flash_cycles;
  logic             walk, dont_walk, ped_wait, abort, fault;
  logic [CNT_W-1:0] remaining;
  ped_state_e       state_dbg;

  int checks = 0;
  int errors = 0;

  ped_crossing_ctrl #(.CNT_W(CNT_W), .FLASH_HALF(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .greenlt      (greenlt),
    .yellowlt     (yellowlt),
    .redlt        (redlt),
    .ped_btn      (ped_btn),
    .walk_cycles  (walk_cycles),
    .flash_cycles (flash_cycles),
    .walk         (walk),
    .dont_walk    (dont_walk),
    .ped_wait     (ped_wait),
    .remaining    (remaining),
    .abort        (abort),
    .fault        (fault),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_lights(input logic g, input logic y, input logic r);
    greenlt  = g;
    yellowlt = y;
    redlt    = r;
  endtask

  // Hold the button until the request is latched (bounded).
  task automatic press_button(input string tag);
    ped_btn = 1'b1;
    for (int i = 0; i < 10 && ped_wait !== 1'b1; i++) step();
    ped_btn = 1'b0;
    checks++;
    if (ped_wait !== 1'b1) begin
      errors++;
      $display("FAIL %s_ped_wait_latch got=%b want=1", tag, ped_wait);
    end
  endtask

  // Green, request, yellow, then red rise; returns one cycle into WALK.
  task automatic request_and_cross(input string tag);
    set_lights(1, 0, 0);
    step();
    press_button(tag);
    set_lights(0, 1, 0);
    step();
    set_lights(0, 0, 1);
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    step(2);
    checks++;
    if ({walk, dont_walk, ped_wait, abort, fault} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_flags got=%b want=01000", {walk, dont_walk, ped_wait, abort, fault});
    end
    checks++;
    if (remaining !== 16'd0 || state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_rem_state got=%0d/%0d want=0/0", remaining, state_dbg);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_normal_crossing();
    walk_cycles  = 16'd5;
    flash_cycles = 16'd8;
    request_and_cross("normal");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({walk, dont_walk, ped_wait, abort, fault} !== 5'b10000 || remaining !== 16'(5 - i)) begin
        errors++;
        $display("FAIL normal_walk[%0d] got=%b rem=%0d want=10000 rem=%0d", i,
                 {walk, dont_walk, ped_wait, abort, fault}, remaining, 5 - i);
      end
      step();
    end
    for (int j = 0; j < 8; j++) begin
      logic dw_exp;
      dw_exp = (j < 4);
      checks++;
      if ({walk, dont_walk, ped_wait, abort, fault} !== {1'b0, dw_exp, 3'b000} ||
          remaining !== 16'(8 - j)) begin
        errors++;
        $display("FAIL normal_clear[%0d] got=%b rem=%0d want=0%b000 rem=%0d", j,
                 {walk, dont_walk, ped_wait, abort, fault}, remaining, dw_exp, 8 - j);
      end
      step();
    end
    checks++;
    if ({walk, dont_walk, ped_wait, abort, fault} !== 5'b01000 || remaining !== 16'd0) begin
      errors++;
      $display("FAIL normal_idle got=%b rem=%0d want=01000 rem=0",
               {walk, dont_walk, ped_wait, abort, fault}, remaining);
    end
  endtask

  task automatic test_red_already_high();
    press_button("late");
    step(6);
    checks++;
    if (walk !== 1'b0 || ped_wait !== 1'b1) begin
      errors++;
      $display("FAIL late_no_walk got walk=%b ped_wait=%b want walk=0 ped_wait=1", walk, ped_wait);
    end
    set_lights(1, 0, 0);
    step();
    set_lights(0, 0, 1);
    step();
    checks++;
    if ({walk, dont_walk, ped_wait} !== 3'b100 || remaining !== 16'd5) begin
      errors++;
      $display("FAIL late_walk_start got=%b rem=%0d want=100 rem=5",
               {walk, dont_walk, ped_wait}, remaining);
    end
    step(13);
    checks++;
    if ({walk, dont_walk, abort} !== 3'b010 || remaining !== 16'd0 || state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL late_return_idle got=%b rem=%0d st=%0d want=010 rem=0 st=0",
               {walk, dont_walk, abort}, remaining, state_dbg);
    end
  endtask

  task automatic test_abort();
    request_and_cross("abort");
    step();
    checks++;
    if (walk !== 1'b1 || remaining !== 16'd4) begin
      errors++;
      $display("FAIL abort_pre got walk=%b rem=%0d want walk=1 rem=4", walk, remaining);
    end
    set_lights(1, 0, 0);
    step();
    checks++;
    if ({walk, dont_walk, ped_wait, abort, fault} !== 5'b01010 || remaining !== 16'd0) begin
      errors++;
      $display("FAIL abort_pulse got=%b rem=%0d want=01010 rem=0",
               {walk, dont_walk, ped_wait, abort, fault}, remaining);
    end
    step();
    checks++;
    if (abort !== 1'b0 || state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL abort_one_cycle got abort=%b st=%0d want abort=0 st=0", abort, state_dbg);
    end
  endtask

  task automatic test_fault();
    request_and_cross("fault");
    step(5);
    checks++;
    if ({walk, dont_walk} !== 2'b01 || remaining !== 16'd8) begin
      errors++;
      $display("FAIL fault_clear_entry got=%b rem=%0d want=01 rem=8", {walk, dont_walk}, remaining);
    end
    step(2);
    set_lights(1, 0, 1);
    step();
    checks++;
    if ({walk, dont_walk, ped_wait, abort, fault} !== 5'b01001 || remaining !== 16'd0 ||
        state_dbg !== ST_FAULT) begin
      errors++;
      $display("FAIL fault_enter got=%b rem=%0d st=%0d want=01001 rem=0 st=3",
               {walk, dont_walk, ped_wait, abort, fault}, remaining, state_dbg);
    end
    set_lights(1, 0, 0);
    step(2);
    set_lights(0, 0, 1);
    ped_btn = 1'b1;
    step(5);
    ped_btn = 1'b0;
    checks++;
    if ({walk, dont_walk, ped_wait, abort, fault} !== 5'b01001) begin
      errors++;
      $display("FAIL fault_sticky got=%b want=01001", {walk, dont_walk, ped_wait, abort, fault});
    end
    set_lights(1, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({walk, dont_walk, ped_wait, abort, fault} !== 5'b01000 || state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL fault_reset_exit got=%b st=%0d want=01000 st=0",
               {walk, dont_walk, ped_wait, abort, fault}, state_dbg);
    end
    step();
  endtask

  task automatic test_short_walk();
    walk_cycles = 16'd0;
    request_and_cross("short");
    checks++;
    if ({walk, dont_walk, ped_wait} !== 3'b100 || remaining !== 16'd1) begin
      errors++;
      $display("FAIL short_walk got=%b rem=%0d want=100 rem=1", {walk, dont_walk, ped_wait}, remaining);
    end
    step();
    checks++;
    if ({walk, dont_walk, ped_wait} !== 3'b010 || remaining !== 16'd8) begin
      errors++;
      $display("FAIL short_clear_entry got=%b rem=%0d want=010 rem=8",
               {walk, dont_walk, ped_wait}, remaining);
    end
    ped_btn = 1'b1;
    step(3);
    ped_btn = 1'b0;
    checks++;
    if ({walk, dont_walk, ped_wait} !== 3'b011 || remaining !== 16'd5) begin
      errors++;
      $display("FAIL short_btn_in_clear got=%b rem=%0d want=011 rem=5",
               {walk, dont_walk, ped_wait}, remaining);
    end
    step(4);
    checks++;
    if ({walk, dont_walk, ped_wait} !== 3'b001 || remaining !== 16'd1) begin
      errors++;
      $display("FAIL short_clear_last got=%b rem=%0d want=001 rem=1",
               {walk, dont_walk, ped_wait}, remaining);
    end
    step();
    checks++;
    if ({walk, dont_walk, ped_wait, abort} !== 4'b0110 || remaining !== 16'd0) begin
      errors++;
      $display("FAIL short_idle_wait got=%b rem=%0d want=0110 rem=0",
               {walk, dont_walk, ped_wait, abort}, remaining);
    end
  endtask

  task automatic test_reset_mid_clear();
    walk_cycles = 16'd2;
    set_lights(1, 0, 0);
    step();
    set_lights(0, 0, 1);
    step();
    checks++;
    if ({walk, ped_wait} !== 2'b10 || remaining !== 16'd2) begin
      errors++;
      $display("FAIL rst_walk_start got=%b rem=%0d want=10 rem=2", {walk, ped_wait}, remaining);
    end
    step(3);
    checks++;
    if (state_dbg !== ST_CLEAR || remaining !== 16'd7) begin
      errors++;
      $display("FAIL rst_in_clear got st=%0d rem=%0d want st=2 rem=7", state_dbg, remaining);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({walk, dont_walk, ped_wait, abort, fault} !== 5'b01000 || remaining !== 16'd0 ||
        state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL rst_mid_clear got=%b rem=%0d st=%0d want=01000 rem=0 st=0",
               {walk, dont_walk, ped_wait, abort, fault}, remaining, state_dbg);
    end
    reset = 1'b0;
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset        = 1'b1;
    ped_btn      = 1'b0;
    walk_cycles  = 16'd5;
    flash_cycles = 16'd8;
    set_lights(1, 0, 0);
    test_reset();
    test_normal_crossing();
    test_red_already_high();
    test_abort();
    test_fault();
    test_short_walk();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
